// File: rtl/control_miscare_param.sv
// Line-follower motion controller: sensor capture, steering FSM,
// finish-marker debounce and lap counting with circuit-dependent targets.
module control_miscare_param #(
  parameter int             N_SENZ      = 5,
  parameter int             DC_W        = 12,
  parameter logic [DC_W-1:0] DC_MAX     = 12'h998,
  parameter logic [DC_W-1:0] DC_CURBA   = 12'h700,
  parameter int             DEB         = 4,
  parameter int             SEARCH_TO   = 8,
  parameter int             TURE_W      = 8,
  parameter int             TINTA_CURBE = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_SENZ-1:0] senzori,
  input  logic [1:0]        circuit,
  input  logic              start,
  output logic [1:0]        directie_driverA,
  output logic [1:0]        directie_driverB,
  output logic [DC_W-1:0]   factor_dc_driverA,
  output logic [DC_W-1:0]   factor_dc_driverB,
  output logic              semnal_dreapta,
  output logic              semnal_stanga,
  output logic              stop,
  output logic [TURE_W-1:0] count_ture,
  output logic              terminat,
  output logic [2:0]        stare
);
  localparam int C      = (N_SENZ - 1) / 2;
  localparam int DEB_W  = $clog2(DEB + 1);
  localparam int SRCH_W = $clog2(SEARCH_TO + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0, FOLLOW = 3'd1, SEARCH_A = 3'd2,
    SEARCH_B = 3'd3, LOST = 3'd4, DONE = 3'd5
  } st_t;

  localparam logic [1:0] ULT_NONE = 2'd0, ULT_A = 2'd1, ULT_B = 2'd2;
  localparam logic [1:0] FWD = 2'b10, REV = 2'b01, BRK = 2'b00;

  logic [N_SENZ-1:0] s_q;
  st_t               st_q, st_d;
  logic [1:0]        ult_q;
  logic [DEB_W-1:0]  deb_q;
  logic              lat_q;
  logic [SRCH_W-1:0] srch_q;
  logic [TURE_W-1:0] cnt_q;

  logic centru, side_a, side_b, marker, accept, run_cnt, restart, tgt_hit;

  assign centru  = s_q[C];
  assign side_a  = |s_q[C-1:1];
  assign side_b  = |s_q[N_SENZ-2:C+1];
  assign marker  = s_q[0] & s_q[N_SENZ-1];
  // one pulse on the DEB-th consecutive marker cycle, then locked until low
  assign accept  = marker & ~lat_q & (deb_q == DEB_W'(DEB - 1));
  assign run_cnt = (st_q == FOLLOW) || (st_q == SEARCH_A) || (st_q == SEARCH_B);
  assign restart = start && ((st_q == IDLE) || (st_q == DONE));

  assign stare      = st_q;
  assign count_ture = cnt_q;

  // lap target for the currently selected circuit
  always_comb begin
    tgt_hit = 1'b0;
    case (circuit)
      2'b01:   tgt_hit = (cnt_q != '0);
      2'b10:   tgt_hit = (int'(cnt_q) >= TINTA_CURBE);
      default: tgt_hit = 1'b0;
    endcase
  end

  // next-state selection; lap target dominates every run state
  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE, DONE: if (start) st_d = FOLLOW;
      FOLLOW: begin
        if (tgt_hit)                st_d = DONE;
        else if (!centru) begin
          if (ult_q == ULT_A)       st_d = SEARCH_A;
          else if (ult_q == ULT_B)  st_d = SEARCH_B;
          else                      st_d = LOST;
        end
      end
      SEARCH_A, SEARCH_B: begin
        if (tgt_hit)                                  st_d = DONE;
        else if (centru)                              st_d = FOLLOW;
        else if (srch_q == SRCH_W'(SEARCH_TO - 1))    st_d = LOST;
      end
      LOST: begin
        if (tgt_hit)     st_d = DONE;
        else if (centru) st_d = FOLLOW;
      end
      default: st_d = IDLE;
    endcase
  end

  // sensor capture and registered turn indicators
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q            <= '0;
      semnal_dreapta <= 1'b0;
      semnal_stanga  <= 1'b0;
    end else begin
      s_q            <= senzori;
      semnal_dreapta <= s_q[0];
      semnal_stanga  <= s_q[N_SENZ-1];
    end
  end

  // marker debounce: count consecutive high cycles, latch after acceptance
  always_ff @(posedge clk) begin
    if (!rst_n || !marker) begin
      deb_q <= '0;
      lat_q <= 1'b0;
    end else if (accept) begin
      lat_q <= 1'b1;
    end else if (!lat_q) begin
      deb_q <= deb_q + 1'b1;
    end
  end

  // lap counter: cleared on run start, forced to zero in hold mode, saturating
  always_ff @(posedge clk) begin
    if (!rst_n || circuit == 2'b00 || restart)
      cnt_q <= '0;
    else if (accept && run_cnt && cnt_q != '1)
      cnt_q <= cnt_q + 1'b1;
  end

  // search timer runs only while staying in a search state
  always_ff @(posedge clk) begin
    if (!rst_n || !((st_q == SEARCH_A) || (st_q == SEARCH_B)))
      srch_q <= '0;
    else
      srch_q <= srch_q + 1'b1;
  end

  // remember which side last pulled the robot while following
  always_ff @(posedge clk) begin
    if (!rst_n || restart)
      ult_q <= ULT_NONE;
    else if (st_d == FOLLOW) begin
      if (side_a && !side_b)      ult_q <= ULT_A;
      else if (side_b && !side_a) ult_q <= ULT_B;
    end
  end

  // state register and registered motor outputs for the state being entered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q              <= IDLE;
      directie_driverA  <= BRK;
      directie_driverB  <= BRK;
      factor_dc_driverA <= '0;
      factor_dc_driverB <= '0;
      stop              <= 1'b1;
      terminat          <= 1'b0;
    end else begin
      st_q     <= st_d;
      terminat <= (st_d == DONE);
      case (st_d)
        FOLLOW: begin
          directie_driverA  <= FWD;
          directie_driverB  <= FWD;
          stop              <= ~centru;
          factor_dc_driverA <= (side_a || !side_b) && side_a ? DC_MAX : DC_CURBA;
          factor_dc_driverB <= side_b ? DC_MAX : DC_CURBA;
        end
        SEARCH_A: begin
          directie_driverA  <= REV;
          directie_driverB  <= FWD;
          factor_dc_driverA <= DC_MAX;
          factor_dc_driverB <= DC_MAX;
          stop              <= ~centru;
        end
        SEARCH_B: begin
          directie_driverA  <= FWD;
          directie_driverB  <= REV;
          factor_dc_driverA <= DC_MAX;
          factor_dc_driverB <= DC_MAX;
          stop              <= ~centru;
        end
        default: begin
          directie_driverA  <= BRK;
          directie_driverB  <= BRK;
          factor_dc_driverA <= '0;
          factor_dc_driverB <= '0;
          stop              <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_control_miscare_param.sv
// Self-checking bench: directed scenarios plus randomized sensor traffic,
// compared every cycle against a lap/steering reference model.
module tb_control_miscare_param;
  localparam int NS = 5, C = 2, DEB = 4, STO = 8, TC = 10;
  localparam logic [11:0] MAXD = 12'h998, CURB = 12'h700;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] senzori = '0;
  logic [1:0] circuit = 2'b01;
  logic start = 1'b0;
  logic [1:0] directie_driverA, directie_driverB;
  logic [11:0] factor_dc_driverA, factor_dc_driverB;
  logic semnal_dreapta, semnal_stanga, stop, terminat;
  logic [7:0] count_ture;
  logic [2:0] stare;

  control_miscare_param dut (
    .clk(clk), .rst_n(rst_n), .senzori(senzori), .circuit(circuit), .start(start),
    .directie_driverA(directie_driverA), .directie_driverB(directie_driverB),
    .factor_dc_driverA(factor_dc_driverA), .factor_dc_driverB(factor_dc_driverB),
    .semnal_dreapta(semnal_dreapta), .semnal_stanga(semnal_stanga), .stop(stop),
    .count_ture(count_ture), .terminat(terminat), .stare(stare)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: state as plain ints, marker as a run length
  int m_st = 0, m_laps = 0, m_side = 0, m_run = 0, m_srch = 0;
  logic [4:0] m_s = '0;
  logic [1:0] e_da, e_db;
  logic [11:0] e_ca, e_cb;
  logic e_stop, e_term, e_sd, e_ss;

  task automatic model_edge();
    int nst, nlaps, tgt;
    bit c, a, b, mk, acc, hit;
    if (!rst_n) begin
      m_st = 0; m_laps = 0; m_side = 0; m_run = 0; m_srch = 0; m_s = '0;
      e_da = 0; e_db = 0; e_ca = 0; e_cb = 0; e_stop = 1; e_term = 0; e_sd = 0; e_ss = 0;
      return;
    end
    c = m_s[C]; a = m_s[1]; b = m_s[3]; mk = m_s[0] & m_s[NS-1];
    acc = 0;
    if (mk) begin m_run++; acc = (m_run == DEB); end else m_run = 0;
    tgt = (circuit == 2'b01) ? 1 : (circuit == 2'b10) ? TC : 0;
    hit = (tgt != 0) && (m_laps >= tgt);
    nst = m_st; nlaps = m_laps;
    case (m_st)
      0, 5: if (start) begin nst = 1; nlaps = 0; m_side = 0; end
      1: if (hit) nst = 5; else if (!c) nst = (m_side == 1) ? 2 : (m_side == 2) ? 3 : 4;
      2, 3: if (hit) nst = 5; else if (c) nst = 1; else if (m_srch == STO - 1) nst = 4;
      4: if (hit) nst = 5; else if (c) nst = 1;
      default: nst = 0;
    endcase
    if (acc && m_st >= 1 && m_st <= 3 && m_laps < 255) nlaps = m_laps + 1;
    if (circuit == 2'b00) nlaps = 0;
    if (nst == 1 && m_st != 0 && m_st != 5) begin
      if (a && !b) m_side = 1;
      else if (b && !a) m_side = 2;
    end
    m_srch = ((nst == 2 || nst == 3) && nst == m_st) ? m_srch + 1 : 0;
    e_term = (nst == 5);
    e_stop = !c;
    case (nst)
      1: begin
        e_da = 2'b10; e_db = 2'b10;
        e_ca = (a && !b) ? MAXD : (a && b) ? MAXD : CURB;
        e_cb = b ? MAXD : CURB;
      end
      2: begin e_da = 2'b01; e_db = 2'b10; e_ca = MAXD; e_cb = MAXD; end
      3: begin e_da = 2'b10; e_db = 2'b01; e_ca = MAXD; e_cb = MAXD; end
      default: begin e_da = 0; e_db = 0; e_ca = 0; e_cb = 0; e_stop = 1; end
    endcase
    e_sd = m_s[0]; e_ss = m_s[NS-1];
    m_st = nst; m_laps = nlaps; m_s = senzori;
  endtask

  task automatic step(input logic [4:0] sz, input logic [1:0] ci, input logic st, input logic rn);
    @(negedge clk);
    senzori = sz; circuit = ci; start = st; rst_n = rn;
    @(posedge clk);
    model_edge();
    #1;
    chk("stare", 32'(stare), 32'(m_st));
    chk("laps", 32'(count_ture), 32'(m_laps));
    chk("dir", {directie_driverA, directie_driverB}, {e_da, e_db});
    chk("duty", {factor_dc_driverA, factor_dc_driverB}, {e_ca, e_cb});
    chk("stop_term", {stop, terminat}, {e_stop, e_term});
    chk("semnal", {semnal_dreapta, semnal_stanga}, {e_sd, e_ss});
  endtask

  task automatic rep(input logic [4:0] sz, input logic [1:0] ci, input int n);
    for (int i = 0; i < n; i++) step(sz, ci, 1'b0, 1'b1);
  endtask

  logic [4:0] pats [9] = '{5'b00100, 5'b00110, 5'b01100, 5'b00010, 5'b01000,
                           5'b10101, 5'b00000, 5'b11111, 5'b01110};

  initial begin
    // reset
    step(5'b10101, 2'b01, 1'b1, 1'b0);
    step(5'b10101, 2'b01, 1'b0, 1'b0);
    chk("rst_stare", 32'(stare), 32'd0);
    chk("rst_stop", 32'(stop), 32'd1);
    // scenario 1: straight start
    step(5'b00100, 2'b11, 1'b1, 1'b1);
    rep(5'b00100, 2'b11, 2);
    chk("s1_stare", 32'(stare), 32'd1);
    chk("s1_duty", {factor_dc_driverA, factor_dc_driverB}, {CURB, CURB});
    chk("s1_stop", 32'(stop), 32'd0);
    // scenario 2: lose line after side A, then time out
    rep(5'b00110, 2'b11, 3);
    rep(5'b00010, 2'b11, 2);
    chk("s2_stare", 32'(stare), 32'd2);
    chk("s2_dir", {directie_driverA, directie_driverB}, 4'b0110);
    rep(5'b00010, 2'b11, 7);
    chk("s2_notyet", 32'(stare), 32'd2);
    rep(5'b00010, 2'b11, 1);
    chk("s2_lost", {stare, stop}, {3'd4, 1'b1});
    rep(5'b00100, 2'b11, 2);
    // scenario 3: debounce boundary, single-lap circuit
    rep(5'b10101, 2'b01, 3);
    rep(5'b00100, 2'b01, 3);
    chk("s3_short", 32'(count_ture), 32'd0);
    rep(5'b10101, 2'b01, 6);
    chk("s3_done", {count_ture, stare, terminat, directie_driverA, directie_driverB},
        {8'd1, 3'd5, 1'b1, 4'b0000});
    // scenario 4: curve circuit, ten laps
    step(5'b00100, 2'b10, 1'b1, 1'b1);
    for (int l = 0; l < 10; l++) begin rep(5'b10101, 2'b10, 6); rep(5'b00100, 2'b10, 3); end
    chk("s4_done", {count_ture, stare}, {8'd10, 3'd5});
    step(5'b00100, 2'b10, 1'b1, 1'b1);
    chk("s4_restart", {count_ture, stare}, {8'd0, 3'd1});
    // scenario 5: endurance saturation
    for (int l = 0; l < 300; l++) begin rep(5'b10101, 2'b11, 5); rep(5'b00100, 2'b11, 2); end
    chk("s5_sat", {count_ture, stare}, {8'd255, 3'd1});
    // scenario 6: reset while searching on side B
    step(5'b00100, 2'b11, 1'b0, 1'b0);
    step(5'b00100, 2'b11, 1'b1, 1'b1);
    rep(5'b00100, 2'b11, 2);
    for (int l = 0; l < 3; l++) begin rep(5'b10101, 2'b11, 5); rep(5'b00100, 2'b11, 2); end
    rep(5'b01100, 2'b11, 2);
    rep(5'b01000, 2'b11, 2);
    chk("s6_srchb", {stare, count_ture}, {3'd3, 8'd3});
    step(5'b01000, 2'b11, 1'b1, 1'b0);
    chk("s6_rst", {stare, count_ture, stop}, {3'd0, 8'd0, 1'b1});
    // randomized traffic
    begin
      logic [4:0] pat;
      logic [1:0] ci;
      int hold;
      ci = 2'b11;
      for (int k = 0; k < 500; k++) begin
        pat = pats[$urandom_range(0, 8)];
        if ($urandom_range(0, 9) == 0) pat = 5'($urandom);
        if ($urandom_range(0, 19) == 0) ci = 2'($urandom);
        hold = $urandom_range(1, 8);
        for (int h = 0; h < hold; h++)
          step(pat, ci, (h == 0) && ($urandom_range(0, 5) == 0), $urandom_range(0, 149) != 0);
      end
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
